// File: rtl/mdc_pkg.sv
// mdc_pkg: shared helpers and constants for the multi-digit counter.
//   dmax(bcd, digit_w)     largest legal digit value (9 for decade, all-ones for binary)
//   start_digit(dsel, dm)  per-digit value the count restarts from in a given direction
//   DIR_UP / DIR_DN        encodings of the direction select input
package mdc_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int dmax(input int bcd, input int digit_w);
    return (bcd != 0) ? 9 : ((1 << digit_w) - 1);
  endfunction

  // Counting up restarts from all zeros; counting down restarts from all DMAX.
  function automatic int start_digit(input logic dsel, input int dm);
    return (dsel == DIR_UP) ? 0 : dm;
  endfunction

endpackage

// File: rtl/mdc_digit.sv
// mdc_digit: one DIGIT_W-bit digit register of the cascaded counter.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (reset value 0)
//   clr         synchronous clear to clr_val (highest priority after reset)
//   load        synchronous load of load_val (caller supplies a legal value)
//   step        advance one position in direction dir this edge
//   dir         1 = up, 0 = down
//   clr_val     value taken on clr
//   load_val    value taken on load
//   q           current digit value
//   at_max      q equals DMAX
//   at_zero     q equals 0
module mdc_digit
  import mdc_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int DMAX    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic               step,
  input  logic               dir,
  input  logic [DIGIT_W-1:0] clr_val,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max,
  output logic               at_zero
);

  localparam logic [DIGIT_W-1:0] DMAX_V = DIGIT_W'(DMAX);

  logic [DIGIT_W-1:0] q_reg;
  logic [DIGIT_W-1:0] q_next;

  assign at_max  = (q_reg == DMAX_V);
  assign at_zero = (q_reg == '0);
  assign q       = q_reg;

  always_comb begin
    q_next = q_reg;
    if (clr) begin
      q_next = clr_val;
    end else if (load) begin
      q_next = load_val;
    end else if (step) begin
      if (dir == DIR_UP) begin
        q_next = at_max ? '0 : (q_reg + DIGIT_W'(1));
      end else begin
        q_next = at_zero ? DMAX_V : (q_reg - DIGIT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

endmodule

// File: rtl/multi_digit_counter.sv
// multi_digit_counter: cascaded up/down counter of DIGITS digit cells, each
// DIGIT_W bits wide, counting in decade (BCD=1) or full binary (BCD=0) radix.
// Ports:
//   mdc_clk       clock, rising edge
//   mdc_rst_n     asynchronous active-low reset (q, wrap, err -> 0)
//   mdc_clr       synchronous clear to the start value of the current direction
//   mdc_en        count enable
//   mdc_dsel      direction: 1 up, 0 down
//   mdc_sat       1 saturate at terminal count, 0 wrap
//   mdc_load      synchronous parallel load (digits clamped to DMAX)
//   mdc_load_val  load value, digit 0 in LSBs
//   mdc_q         count value, digit 0 in LSBs
//   mdc_tc        terminal count for current direction (combinational)
//   mdc_wrap      registered pulse: a wrap happened on the last edge
//   mdc_err       sticky flag: an out-of-range digit was loaded
module multi_digit_counter
  import mdc_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4,
  parameter int BCD     = 1
) (
  input  logic                      mdc_clk,
  input  logic                      mdc_rst_n,
  input  logic                      mdc_clr,
  input  logic                      mdc_en,
  input  logic                      mdc_dsel,
  input  logic                      mdc_sat,
  input  logic                      mdc_load,
  input  logic [DIGITS*DIGIT_W-1:0] mdc_load_val,
  output logic [DIGITS*DIGIT_W-1:0] mdc_q,
  output logic                      mdc_tc,
  output logic                      mdc_wrap,
  output logic                      mdc_err
);

  localparam int                 DMAX_I = dmax(BCD, DIGIT_W);
  localparam logic [DIGIT_W:0]   DMAX_X = (DIGIT_W + 1)'(DMAX_I);
  localparam logic [DIGIT_W-1:0] DMAX_V = DIGIT_W'(DMAX_I);

  // up_chain[i]: every digit below i is at DMAX; dn_chain[i]: every digit below i is 0.
  logic [DIGITS:0]    up_chain;
  logic [DIGITS:0]    dn_chain;
  logic [DIGITS-1:0]  at_max;
  logic [DIGITS-1:0]  at_zero;
  logic [DIGITS-1:0]  load_bad;
  logic [DIGIT_W-1:0] clr_val;
  logic               hold_sat;
  logic               wrap_reg;
  logic               wrap_next;
  logic               err_reg;
  logic               err_next;

  assign up_chain[0] = 1'b1;
  assign dn_chain[0] = 1'b1;
  assign clr_val     = DIGIT_W'(start_digit(mdc_dsel, DMAX_I));

  assign mdc_tc   = (mdc_dsel == DIR_UP) ? up_chain[DIGITS] : dn_chain[DIGITS];
  // Saturation freezes every digit at terminal count instead of rolling over.
  assign hold_sat = mdc_tc & mdc_sat;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [DIGIT_W-1:0] load_raw;
      logic [DIGIT_W-1:0] load_clamped;
      logic               step;

      assign load_raw     = mdc_load_val[gi*DIGIT_W +: DIGIT_W];
      // Widened compare keeps the check meaningful in binary mode, where it is never true.
      assign load_bad[gi] = ({1'b0, load_raw} > DMAX_X);
      assign load_clamped = load_bad[gi] ? DMAX_V : load_raw;

      assign up_chain[gi+1] = up_chain[gi] & at_max[gi];
      assign dn_chain[gi+1] = dn_chain[gi] & at_zero[gi];

      assign step = mdc_en & ~hold_sat &
                    ((mdc_dsel == DIR_UP) ? up_chain[gi] : dn_chain[gi]);

      mdc_digit #(
        .DIGIT_W (DIGIT_W),
        .DMAX    (DMAX_I)
      ) u_digit (
        .clk      (mdc_clk),
        .rst_n    (mdc_rst_n),
        .clr      (mdc_clr),
        .load     (mdc_load),
        .step     (step),
        .dir      (mdc_dsel),
        .clr_val  (clr_val),
        .load_val (load_clamped),
        .q        (mdc_q[gi*DIGIT_W +: DIGIT_W]),
        .at_max   (at_max[gi]),
        .at_zero  (at_zero[gi])
      );
    end
  endgenerate

  always_comb begin
    wrap_next = 1'b0;
    err_next  = err_reg;
    if (mdc_clr) begin
      err_next = 1'b0;
    end else if (mdc_load) begin
      if (|load_bad) begin
        err_next = 1'b1;
      end
    end else begin
      wrap_next = mdc_en & mdc_tc & ~mdc_sat;
    end
  end

  always_ff @(posedge mdc_clk or negedge mdc_rst_n) begin
    if (!mdc_rst_n) begin
      wrap_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      wrap_reg <= wrap_next;
      err_reg  <= err_next;
    end
  end

  assign mdc_wrap = wrap_reg;
  assign mdc_err  = err_reg;

endmodule

// File: tb/tb_multi_digit_counter.sv
// tb_multi_digit_counter: directed checks of a 4-digit BCD counter and a
// 2-digit binary counter sharing clock and control inputs.
module tb_multi_digit_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        en = 1'b0;
  logic        dsel = 1'b1;
  logic        sat = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val_a = '0;
  logic [7:0]  load_val_b = '0;
  logic [15:0] q_a;
  logic [7:0]  q_b;
  logic        tc_a, wrap_a, err_a;
  logic        tc_b, wrap_b, err_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multi_digit_counter #(.DIGITS(4), .DIGIT_W(4), .BCD(1)) u_dut_a (
    .mdc_clk      (clk),
    .mdc_rst_n    (rst_n),
    .mdc_clr      (clr),
    .mdc_en       (en),
    .mdc_dsel     (dsel),
    .mdc_sat      (sat),
    .mdc_load     (load),
    .mdc_load_val (load_val_a),
    .mdc_q        (q_a),
    .mdc_tc       (tc_a),
    .mdc_wrap     (wrap_a),
    .mdc_err      (err_a)
  );

  multi_digit_counter #(.DIGITS(2), .DIGIT_W(4), .BCD(0)) u_dut_b (
    .mdc_clk      (clk),
    .mdc_rst_n    (rst_n),
    .mdc_clr      (clr),
    .mdc_en       (en),
    .mdc_dsel     (dsel),
    .mdc_sat      (sat),
    .mdc_load     (load),
    .mdc_load_val (load_val_b),
    .mdc_q        (q_b),
    .mdc_tc       (tc_b),
    .mdc_wrap     (wrap_b),
    .mdc_err      (err_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %-14s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] va, input logic [7:0] vb);
    load = 1'b1;
    load_val_a = va;
    load_val_b = vb;
    tick();
    load = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_q", q_a, 16'h0000);
    check("rst_wrap", 16'(wrap_a), 16'h0);
    check("rst_err", 16'(err_a), 16'h0);
    check("rst_q_bin", 16'(q_b), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-count asynchronous reset
    do_load(16'h0456, 8'h00);
    dsel = 1'b1; en = 1'b1;
    tick();
    check("pre_rst_q", q_a, 16'h0457);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", q_a, 16'h0000);
    check("async_rst_wr", 16'(wrap_a), 16'h0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Up carry
    do_load(16'h0999, 8'h00);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("up_carry", q_a, 16'h1000);

    // Up wrap
    do_load(16'h9999, 8'h00);
    check("up_tc", 16'(tc_a), 16'h1);
    sat = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    check("up_wrap_q", q_a, 16'h0000);
    check("up_wrap_pulse", 16'(wrap_a), 16'h1);
    tick();
    check("up_wrap_end", 16'(wrap_a), 16'h0);

    // Up saturate
    do_load(16'h9999, 8'h00);
    sat = 1'b1; en = 1'b1;
    tick();
    en = 1'b0;
    check("up_sat_q", q_a, 16'h9999);
    check("up_sat_wrap", 16'(wrap_a), 16'h0);

    // Down borrow
    sat = 1'b0; dsel = 1'b0;
    do_load(16'h1000, 8'h00);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("dn_borrow", q_a, 16'h0999);

    // Down wrap
    do_load(16'h0000, 8'h00);
    check("dn_tc", 16'(tc_a), 16'h1);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("dn_wrap_q", q_a, 16'h9999);
    check("dn_wrap_pulse", 16'(wrap_a), 16'h1);
    tick();
    check("dn_wrap_end", 16'(wrap_a), 16'h0);

    // Down saturate
    do_load(16'h0000, 8'h00);
    sat = 1'b1; en = 1'b1;
    tick();
    en = 1'b0; sat = 1'b0;
    check("dn_sat_q", q_a, 16'h0000);
    check("dn_sat_wrap", 16'(wrap_a), 16'h0);

    // Illegal load, sticky err across counting, cleared by clr
    dsel = 1'b1;
    do_load(16'h12A4, 8'h00);
    check("ill_q", q_a, 16'h1294);
    check("ill_err", 16'(err_a), 16'h1);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("err_sticky", 16'(err_a), 16'h1);
    end
    en = 1'b0;
    check("ill_count_q", q_a, 16'h1304);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_q", q_a, 16'h0000);
    check("clr_err", 16'(err_a), 16'h0);

    // Priority: clr over load over en, down direction
    do_load(16'h00F0, 8'h00);
    check("ill2_err", 16'(err_a), 16'h1);
    dsel = 1'b0; clr = 1'b1; load = 1'b1; en = 1'b1;
    load_val_a = 16'h1234;
    tick();
    clr = 1'b0; load = 1'b0; en = 1'b0;
    check("prio_clr_q", q_a, 16'h9999);
    check("prio_clr_err", 16'(err_a), 16'h0);

    // Priority: load over en
    dsel = 1'b1; load = 1'b1; en = 1'b1;
    load_val_a = 16'h5678;
    tick();
    load = 1'b0; en = 1'b0;
    check("prio_load_q", q_a, 16'h5678);

    // tc follows dsel combinationally
    do_load(16'h0000, 8'h00);
    check("tc_up_zero", 16'(tc_a), 16'h0);
    dsel = 1'b0;
    #1;
    check("tc_dn_zero", 16'(tc_a), 16'h1);

    // Binary mode, 2 digits
    dsel = 1'b1;
    do_load(16'h0000, 8'h0F);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("bin_carry", 16'(q_b), 16'h0010);
    do_load(16'h0000, 8'hFF);
    check("bin_err", 16'(err_b), 16'h0);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("bin_wrap_q", 16'(q_b), 16'h0000);
    check("bin_wrap_p", 16'(wrap_b), 16'h1);
    dsel = 1'b0;
    do_load(16'h0000, 8'h00);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("bin_dn_q", 16'(q_b), 16'h00FF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multi_digit_counter.md
# multi_digit_counter

Parametrised cascaded up/down counter: DIGITS digit cells of DIGIT_W bits, each counting in binary or BCD (decade) radix, with direction select, wrap or saturate end behaviour, parallel load, and cascade/terminal-count outputs. It is the generalised successor of the team's single-digit up/down counter. It sits in display and timing paths, such as seven-segment timers, event counters and down-count timeouts, where multi-digit decimal values are required directly without binary-to-BCD conversion.

## Interface
- DIGITS, 4, number of digit cells (1..8).
- DIGIT_W, 4, bits per digit (BCD=1 requires DIGIT_W>=4).
- BCD, 1, 1: digit max = 9; 0: digit max = 2^DIGIT_W-1.
- mdc_clk  in  1  clock; all state updates on rising edge.
- mdc_rst_n  in  1  asynchronous active-low reset.
- mdc_clr  in  1  synchronous clear to direction start value.
- mdc_en  in  1  count enable.
- mdc_dsel  in  1  direction: 1 up, 0 down.
- mdc_sat  in  1  1: saturate at terminal value; 0: wrap.
- mdc_load  in  1  synchronous parallel load.
- mdc_load_val  in  DIGITS*DIGIT_W  load value; digit 0 in LSBs.
- mdc_q  out  DIGITS*DIGIT_W  count value; digit 0 in LSBs.
- mdc_tc  out  1  terminal count for current direction (combinational).
- mdc_wrap  out  1  one-cycle pulse: a wrap occurred on the last edge.
- mdc_err  out  1  sticky: an illegal digit was loaded.

## Operation
- DMAX = 9 if BCD else 2^DIGIT_W-1; start value: up = all digits 0, down = all digits DMAX.
- Priority per edge: mdc_rst_n low > mdc_clr > mdc_load > mdc_en count > hold.
- mdc_clr: q <= start value for current mdc_dsel, wrap <= 0, err <= 0.
- mdc_load: each digit d of load_val is loaded as min(d, DMAX). If any digit exceeds DMAX, err <= 1, which holds until clr or reset. wrap <= 0.
- Count up: digit i increments when en and all digits below i equal DMAX. A digit at DMAX that increments goes to 0.
- Count down: digit i decrements when en and all digits below i equal 0. A digit at 0 that decrements goes to DMAX.
- mdc_tc = 1 when up and all digits are DMAX, or when down and all digits are 0.
- At tc with en and no clr/load:
  - sat=0: q becomes the start value (wrap), and wrap <= 1 for one cycle.
  - sat=1: q holds and wrap <= 0.
- wrap is 0 on every edge that does not perform a wrap.
- Changing dsel mid-count simply reverses direction from the current value. No digit ever holds a value > DMAX.

## Timing
- Async reset: q = 0, wrap = 0, err = 0 immediately while mdc_rst_n is low. This holds regardless of dsel. Release is synchronous to mdc_clk (external synchroniser).
- q, wrap and err are registered with 1-cycle latency from the inputs.
- tc is combinational from q and dsel, so it flips in the same cycle dsel changes.
- The ripple-enable chain is combinational across all digits, so a full carry takes one cycle. The DIGITS=8 chain must close timing at the target clock.
- Reset asserted mid-count aborts the operation. No wrap pulse is emitted for that cycle.

## Structure
- Package mdc_pkg holds:
  - function dmax(BCD, DIGIT_W)
  - function start_digit(dsel, dmax)
  - direction constants DIR_UP = 1, DIR_DN = 0
- Sub-module mdc_digit: one DIGIT_W-bit digit register. Inputs are step, dir, clear value and load value; outputs are q, at_max and at_zero. The parent generates DIGITS instances and builds the ripple-enable chain, tc, wrap and err.

## Test plan
Defaults are DIGITS=4, BCD=1 unless stated; q is shown as hex digits.
- Reset: mid-count at q=0x0457, pull rst_n low between edges -> q=0x0000, wrap=0 and err=0 immediately, with no clock edge.
- Up carry and wrap:
  - q=0x0999, en=1, dsel=1 -> 0x1000.
  - q=0x9999, sat=0 -> tc=1 beforehand, then q=0x0000 and wrap=1 for exactly one cycle.
  - Same case with sat=1 -> q stays 0x9999, wrap=0.
- Down borrow and wrap:
  - q=0x1000, dsel=0 -> 0x0999.
  - q=0x0000, sat=0 -> 0x9999 with a wrap pulse.
  - Same case with sat=1 -> q holds 0x0000.
- Illegal load: load_val=0x12A4 -> q=0x1294 and err=1. err stays 1 across 10 count cycles and clears only on clr.
- Priority:
  - clr, load and en together with dsel=0 -> q=0x9999, err=0.
  - load and en together -> q=load_val; no count that cycle.
- Binary mode, DIGITS=2, BCD=0:
  - 0x0F up -> 0x10.
  - 0xFF up with sat=0 -> 0x00 with a wrap pulse.
  - 0x00 down -> 0xFF.
